// File: rtl/eth_rx_fcs_check_if.sv
// Stream and status bundle for the Ethernet receive FCS checker.
// The master side drives the input byte stream. The slave side is the checker, which
// drives the processed stream, the per-frame status strobes and the counters.
interface eth_rx_fcs_check_if #(
  parameter int unsigned LEN_W = 11,
  parameter int unsigned CNT_W = 16
);
  logic [9:0]       IN_ETH_STREAM;   // {CKE, FRM, DAT[7:0]}
  logic [9:0]       OUT_ETH_STREAM;  // same format, processed
  logic             OUT_START_STB;
  logic             OUT_END_STB;
  logic             OUT_OK_STB;
  logic             OUT_BAD_STB;
  logic             OUT_CRC_ERR;
  logic             OUT_RUNT;
  logic             OUT_GIANT;
  logic [LEN_W-1:0] OUT_LEN;
  logic [CNT_W-1:0] OUT_OK_CNT;
  logic [CNT_W-1:0] OUT_BAD_CNT;

  modport master (
    output IN_ETH_STREAM,
    input  OUT_ETH_STREAM, OUT_START_STB, OUT_END_STB, OUT_OK_STB, OUT_BAD_STB,
    input  OUT_CRC_ERR, OUT_RUNT, OUT_GIANT, OUT_LEN, OUT_OK_CNT, OUT_BAD_CNT
  );

  modport slave (
    input  IN_ETH_STREAM,
    output OUT_ETH_STREAM, OUT_START_STB, OUT_END_STB, OUT_OK_STB, OUT_BAD_STB,
    output OUT_CRC_ERR, OUT_RUNT, OUT_GIANT, OUT_LEN, OUT_OK_CNT, OUT_BAD_CNT
  );
endinterface

// File: rtl/eth_rx_fcs_check.sv
// Ethernet receive FCS checker and stripper.
// The block computes a reflected CRC-32 over each frame and measures the frame length
// against the runt and giant limits. When STRIP_FCS is set, it drops the trailing four
// FCS bytes through a four-entry delay line. Each frame ends with one registered status
// strobe, and the good and bad frame counters saturate.
module eth_rx_fcs_check #(
  parameter bit          STRIP_FCS = 1'b1,
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 1518,
  parameter int unsigned LEN_W     = 11,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                CLK,
  input  logic                RST,
  eth_rx_fcs_check_if.slave   bus
);

  localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
  localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

  typedef enum logic [1:0] {StSync, StIdle, StFrame} state_e;

  // One byte of reflected CRC-32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CrcPoly;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // Input fields
  logic       in_cke;
  logic       in_frm;
  logic [7:0] in_dat;

  assign in_cke = bus.IN_ETH_STREAM[9];
  assign in_frm = bus.IN_ETH_STREAM[8];
  assign in_dat = bus.IN_ETH_STREAM[7:0];

  // Frame state
  state_e           state_q;
  logic [31:0]      crc_q;
  logic [31:0]      crc_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_inc;
  logic [7:0]       dly_q [4];

  // Registered outputs
  logic [9:0]       out_stream_q;
  logic             start_q;
  logic             end_q;
  logic             ok_q;
  logic             bad_q;
  logic             crc_err_q;
  logic             runt_q;
  logic             giant_q;
  logic [LEN_W-1:0] len_out_q;
  logic [CNT_W-1:0] ok_cnt_q;
  logic [CNT_W-1:0] bad_cnt_q;

  // End-of-frame verdict, evaluated on the ending beat
  logic frame_end;
  logic crc_good;
  logic len_runt;
  logic len_giant;
  logic frame_ok;

  // The CRC is reseeded on the first byte of a frame, so no separate init cycle is needed.
  always_comb begin
    crc_d = crc_byte((state_q == StIdle) ? CrcInit : crc_q, in_dat);
  end

  // Length increment and the end-of-frame classification
  always_comb begin
    len_inc   = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + 1'b1;
    frame_end = in_cke && !in_frm && (state_q == StFrame);
    crc_good  = (crc_q == CrcResidue);
    len_runt  = 32'(len_q) < MIN_LEN;
    len_giant = 32'(len_q) > MAX_LEN;
    frame_ok  = crc_good && !len_runt && !len_giant;
  end

  // Frame FSM, delay line and registered stream/status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StSync;
      crc_q        <= CrcInit;
      len_q        <= '0;
      for (int i = 0; i < 4; i++) dly_q[i] <= '0;
      out_stream_q <= '0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      ok_q         <= 1'b0;
      bad_q        <= 1'b0;
      crc_err_q    <= 1'b0;
      runt_q       <= 1'b0;
      giant_q      <= 1'b0;
      len_out_q    <= '0;
    end else begin
      // Output CKE is always the input CKE one cycle late. FRM and DAT stay zero unless
      // a byte is emitted.
      out_stream_q <= {in_cke, 9'b0};
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      ok_q         <= 1'b0;
      bad_q        <= 1'b0;
      crc_err_q    <= 1'b0;
      runt_q       <= 1'b0;
      giant_q      <= 1'b0;
      if (in_cke) begin
        unique case (state_q)
          StSync: begin
            if (!in_frm) state_q <= StIdle;
          end
          StIdle: begin
            if (in_frm) begin
              state_q  <= StFrame;
              crc_q    <= crc_d;
              len_q    <= LEN_W'(1);
              dly_q[0] <= in_dat;
              for (int i = 1; i < 4; i++) dly_q[i] <= dly_q[i-1];
              if (!STRIP_FCS) begin
                out_stream_q <= {2'b11, in_dat};
                start_q      <= 1'b1;
              end
            end
          end
          StFrame: begin
            if (in_frm) begin
              crc_q    <= crc_d;
              len_q    <= len_inc;
              dly_q[0] <= in_dat;
              for (int i = 1; i < 4; i++) dly_q[i] <= dly_q[i-1];
              if (STRIP_FCS) begin
                // len_q counts the bytes already absorbed, so dly_q[3] is byte len_q-4.
                if (len_q >= LEN_W'(4)) begin
                  out_stream_q <= {2'b11, dly_q[3]};
                  start_q      <= (len_q == LEN_W'(4));
                end
              end else begin
                out_stream_q <= {2'b11, in_dat};
              end
            end else begin
              state_q   <= StIdle;
              end_q     <= 1'b1;
              ok_q      <= frame_ok;
              bad_q     <= !frame_ok;
              crc_err_q <= !crc_good;
              runt_q    <= len_runt;
              giant_q   <= len_giant;
              len_out_q <= len_q;
              for (int i = 0; i < 4; i++) dly_q[i] <= '0;
            end
          end
          default: state_q <= StSync;
        endcase
      end
    end
  end

  // Saturating good and bad frame counters, updated together with the END strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      ok_cnt_q  <= '0;
      bad_cnt_q <= '0;
    end else if (frame_end) begin
      if (frame_ok) begin
        if (ok_cnt_q != {CNT_W{1'b1}}) ok_cnt_q <= ok_cnt_q + 1'b1;
      end else begin
        if (bad_cnt_q != {CNT_W{1'b1}}) bad_cnt_q <= bad_cnt_q + 1'b1;
      end
    end
  end

  assign bus.OUT_ETH_STREAM = out_stream_q;
  assign bus.OUT_START_STB  = start_q;
  assign bus.OUT_END_STB    = end_q;
  assign bus.OUT_OK_STB     = ok_q;
  assign bus.OUT_BAD_STB    = bad_q;
  assign bus.OUT_CRC_ERR    = crc_err_q;
  assign bus.OUT_RUNT       = runt_q;
  assign bus.OUT_GIANT      = giant_q;
  assign bus.OUT_LEN        = len_out_q;
  assign bus.OUT_OK_CNT     = ok_cnt_q;
  assign bus.OUT_BAD_CNT    = bad_cnt_q;

endmodule
